// File: rtl/cdr_pd_monitor_if.sv
// cdr_pd_monitor_if: sampled PD/data inputs and lock/error/count outputs.
// master drives en/clr_err/d/up/down; slave (the monitor) drives the status.
interface cdr_pd_monitor_if #(
    parameter int NCH   = 1,
    parameter int CNT_W = 16
);
    logic                 en;
    logic                 clr_err;
    logic [NCH-1:0]       d;
    logic [NCH-1:0]       up;
    logic [NCH-1:0]       down;
    logic [NCH-1:0]       locked;
    logic [NCH-1:0]       err_stuck;
    logic [NCH-1:0]       err_overlap;
    logic [NCH-1:0]       err_run;
    logic [NCH*CNT_W-1:0] up_cnt;
    logic [NCH*CNT_W-1:0] down_cnt;
    logic                 win_done;

    modport master (
        output en, clr_err, d, up, down,
        input  locked, err_stuck, err_overlap, err_run,
        input  up_cnt, down_cnt, win_done
    );

    modport slave (
        input  en, clr_err, d, up, down,
        output locked, err_stuck, err_overlap, err_run,
        output up_cnt, down_cnt, win_done
    );
endinterface

// File: rtl/cdr_pd_monitor.sv
// cdr_pd_monitor: per-channel PD UP/DOWN window counts, lock FSM with
// hysteresis, sticky stuck/overlap/run-length errors. Ports: refclk, rst_n, bus.
module cdr_pd_monitor #(
    parameter int NCH         = 1,
    parameter int WIN_LEN     = 256,
    parameter int CNT_W       = 16,
    parameter int LOCK_TOL    = 8,
    parameter int LOCK_WINS   = 4,
    parameter int STUCK_MAX   = 16,
    parameter int OVERLAP_MAX = 2,
    parameter int RUN_MAX     = 64
) (
    input logic          refclk,
    input logic          rst_n,
    cdr_pd_monitor_if.slave bus
);
    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int BAL_W = $clog2(LOCK_WINS + 1);
    localparam int STK_W = $clog2(STUCK_MAX + 2);
    localparam int OVL_W = $clog2(OVERLAP_MAX + 2);
    localparam int RUN_W = $clog2(RUN_MAX + 2);
    localparam int CW1   = CNT_W + 1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [BAL_W-1:0] BAL_TOP  = BAL_W'(LOCK_WINS);
    localparam logic [STK_W-1:0] STK_TOP  = STK_W'(STUCK_MAX + 1);
    localparam logic [OVL_W-1:0] OVL_TOP  = OVL_W'(OVERLAP_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_TOP  = RUN_W'(RUN_MAX + 1);
    localparam logic [CNT_W:0]   TOL      = CW1'(LOCK_TOL);

    typedef enum logic [1:0] {UNLOCKED, LOCKED, HOLD} state_e;

    logic             samp;
    logic             last;
    logic [WIN_W-1:0] win_q, win_d;
    logic             win_done_q;

    assign samp = bus.en;
    assign last = samp && (win_q == WIN_LAST);
    assign win_d = !samp ? win_q : (last ? '0 : win_q + 1'b1);

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            win_q      <= '0;
            win_done_q <= 1'b0;
        end else begin
            win_q      <= win_d;
            win_done_q <= last;
        end
    end

    assign bus.win_done = win_done_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             u_b, dn_b, d_b, clr;
        logic [CNT_W-1:0] up_acc_q, up_acc_d, dn_acc_q, dn_acc_d;
        logic [CNT_W-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
        logic [CNT_W-1:0] up_tot, dn_tot;
        logic [CNT_W:0]   diff, mag;
        logic             bal;
        state_e           st_q, st_d;
        logic [BAL_W-1:0] bal_q, bal_d, bal_inc;
        logic [STK_W-1:0] us_q, us_d, ds_q, ds_d;
        logic [OVL_W-1:0] ov_q, ov_d;
        logic [RUN_W-1:0] rn_q, rn_d;
        logic             pd_q, pd_d;
        logic             es_q, es_d, eo_q, eo_d, er_q, er_d;

        assign u_b  = bus.up[i];
        assign dn_b = bus.down[i];
        assign d_b  = bus.d[i];
        assign clr  = bus.clr_err;

        always_comb begin
            up_tot = up_acc_q + CNT_W'(u_b);
            dn_tot = dn_acc_q + CNT_W'(dn_b);
            diff   = {1'b0, up_tot} - {1'b0, dn_tot};
            mag    = diff[CNT_W] ? -diff : diff;
            // An empty window carries no phase information.
            bal    = (mag <= TOL) && ((up_tot | dn_tot) != '0);

            up_acc_d = up_acc_q;
            dn_acc_d = dn_acc_q;
            up_cnt_d = up_cnt_q;
            dn_cnt_d = dn_cnt_q;
            us_d     = us_q;
            ds_d     = ds_q;
            ov_d     = ov_q;
            rn_d     = rn_q;
            pd_d     = pd_q;
            if (samp) begin
                up_acc_d = last ? '0 : up_tot;
                dn_acc_d = last ? '0 : dn_tot;
                if (last) begin
                    up_cnt_d = up_tot;
                    dn_cnt_d = dn_tot;
                end
                us_d = !u_b ? '0 :
                       (us_q == STK_TOP ? us_q : us_q + 1'b1);
                ds_d = !dn_b ? '0 :
                       (ds_q == STK_TOP ? ds_q : ds_q + 1'b1);
                ov_d = !(u_b && dn_b) ? '0 :
                       (ov_q == OVL_TOP ? ov_q : ov_q + 1'b1);
                rn_d = (d_b != pd_q) ? RUN_W'(1) :
                       (rn_q == RUN_TOP ? rn_q : rn_q + 1'b1);
                pd_d = d_b;
            end
            // A violation on the clearing edge wins over the clear.
            es_d = (es_q && !clr) ||
                   (samp && (us_d == STK_TOP || ds_d == STK_TOP));
            eo_d = (eo_q && !clr) || (samp && ov_d == OVL_TOP);
            er_d = (er_q && !clr) || (samp && rn_d == RUN_TOP);
        end

        always_comb begin
            st_d    = st_q;
            bal_d   = bal_q;
            bal_inc = bal_q + 1'b1;
            if (last) begin
                unique case (st_q)
                    UNLOCKED: begin
                        if (!bal) begin
                            bal_d = '0;
                        end else if (bal_inc == BAL_TOP) begin
                            st_d  = LOCKED;
                            bal_d = '0;
                        end else begin
                            bal_d = bal_inc;
                        end
                    end
                    LOCKED: begin
                        if (!bal) st_d = HOLD;
                    end
                    HOLD: begin
                        st_d  = bal ? LOCKED : UNLOCKED;
                        bal_d = '0;
                    end
                    default: begin
                        st_d  = UNLOCKED;
                        bal_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge refclk) begin
            if (!rst_n) begin
                up_acc_q <= '0;
                dn_acc_q <= '0;
                up_cnt_q <= '0;
                dn_cnt_q <= '0;
                st_q     <= UNLOCKED;
                bal_q    <= '0;
                us_q     <= '0;
                ds_q     <= '0;
                ov_q     <= '0;
                rn_q     <= '0;
                pd_q     <= 1'b0;
                es_q     <= 1'b0;
                eo_q     <= 1'b0;
                er_q     <= 1'b0;
            end else begin
                up_acc_q <= up_acc_d;
                dn_acc_q <= dn_acc_d;
                up_cnt_q <= up_cnt_d;
                dn_cnt_q <= dn_cnt_d;
                st_q     <= st_d;
                bal_q    <= bal_d;
                us_q     <= us_d;
                ds_q     <= ds_d;
                ov_q     <= ov_d;
                rn_q     <= rn_d;
                pd_q     <= pd_d;
                es_q     <= es_d;
                eo_q     <= eo_d;
                er_q     <= er_d;
            end
        end

        assign bus.locked[i]                    = (st_q != UNLOCKED);
        assign bus.err_stuck[i]                 = es_q;
        assign bus.err_overlap[i]               = eo_q;
        assign bus.err_run[i]                   = er_q;
        assign bus.up_cnt[i*CNT_W +: CNT_W]     = up_cnt_q;
        assign bus.down_cnt[i*CNT_W +: CNT_W]   = dn_cnt_q;
    end
endmodule

// File: tb/tb_cdr_pd_monitor.sv
// tb_cdr_pd_monitor: directed + random stimulus against a behavioural
// model of window counts, lock hysteresis and sticky run-length errors.
module tb_cdr_pd_monitor;
    localparam int NCH = 2;
    localparam int WL  = 16;
    localparam int CW  = 16;
    localparam int TOL = 2;
    localparam int LW  = 3;
    localparam int SM  = 4;
    localparam int OM  = 1;
    localparam int RM  = 8;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 refclk = ~refclk;

    cdr_pd_monitor_if #(.NCH(NCH), .CNT_W(CW)) bus ();

    cdr_pd_monitor #(
        .NCH(NCH), .WIN_LEN(WL), .CNT_W(CW), .LOCK_TOL(TOL),
        .LOCK_WINS(LW), .STUCK_MAX(SM), .OVERLAP_MAX(OM), .RUN_MAX(RM)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_pos;
    bit m_wd;
    int m_ua[NCH], m_da[NCH], m_uc[NCH], m_dc[NCH];
    int m_str[NCH], m_miss[NCH];
    int m_ur[NCH], m_dr[NCH], m_or[NCH], m_rr[NCH];
    bit m_lk[NCH], m_pd[NCH], m_es[NCH], m_eo[NCH], m_er[NCH];

    task automatic mreset();
        m_pos = 0;
        m_wd  = 0;
        for (int c = 0; c < NCH; c++) begin
            m_ua[c] = 0; m_da[c] = 0; m_uc[c] = 0; m_dc[c] = 0;
            m_str[c] = 0; m_miss[c] = 0;
            m_ur[c] = 0; m_dr[c] = 0; m_or[c] = 0; m_rr[c] = 0;
            m_lk[c] = 0; m_pd[c] = 0;
            m_es[c] = 0; m_eo[c] = 0; m_er[c] = 0;
        end
    endtask

    task automatic mstep(input bit e, input bit clr, input logic [1:0] dd,
                         input logic [1:0] u, input logic [1:0] dn);
        bit endw, bl;
        int df;
        endw = e && (m_pos == WL - 1);
        m_wd = endw;
        for (int c = 0; c < NCH; c++) begin
            if (clr) begin
                m_es[c] = 0; m_eo[c] = 0; m_er[c] = 0;
            end
            if (e) begin
                m_ua[c] += int'(u[c]);
                m_da[c] += int'(dn[c]);
                m_ur[c] = u[c] ? m_ur[c] + 1 : 0;
                m_dr[c] = dn[c] ? m_dr[c] + 1 : 0;
                m_or[c] = (u[c] && dn[c]) ? m_or[c] + 1 : 0;
                m_rr[c] = (dd[c] == m_pd[c]) ? m_rr[c] + 1 : 1;
                m_pd[c] = dd[c];
                if (m_ur[c] > SM || m_dr[c] > SM) m_es[c] = 1;
                if (m_or[c] > OM) m_eo[c] = 1;
                if (m_rr[c] > RM) m_er[c] = 1;
                if (endw) begin
                    m_uc[c] = m_ua[c];
                    m_dc[c] = m_da[c];
                    m_ua[c] = 0;
                    m_da[c] = 0;
                    df = m_uc[c] - m_dc[c];
                    if (df < 0) df = -df;
                    bl = (df <= TOL) && (m_uc[c] + m_dc[c] > 0);
                    if (!m_lk[c]) begin
                        m_str[c] = bl ? m_str[c] + 1 : 0;
                        if (m_str[c] == LW) begin
                            m_lk[c] = 1; m_str[c] = 0; m_miss[c] = 0;
                        end
                    end else begin
                        m_miss[c] = bl ? 0 : m_miss[c] + 1;
                        if (m_miss[c] == 2) begin
                            m_lk[c] = 0; m_str[c] = 0; m_miss[c] = 0;
                        end
                    end
                end
            end
        end
        if (e) m_pos = endw ? 0 : m_pos + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0]    lk, es, eo, er;
        logic [NCH*CW-1:0] uc, dc;
        for (int c = 0; c < NCH; c++) begin
            lk[c] = m_lk[c];
            es[c] = m_es[c];
            eo[c] = m_eo[c];
            er[c] = m_er[c];
            uc[c*CW +: CW] = CW'(m_uc[c]);
            dc[c*CW +: CW] = CW'(m_dc[c]);
        end
        chk("win_done", bus.win_done, m_wd);
        chk("locked", bus.locked, lk);
        chk("err_stuck", bus.err_stuck, es);
        chk("err_overlap", bus.err_overlap, eo);
        chk("err_run", bus.err_run, er);
        chk("up_cnt", bus.up_cnt, uc);
        chk("down_cnt", bus.down_cnt, dc);
    endtask

    task automatic step(input bit e, input bit clr, input logic [1:0] dd,
                        input logic [1:0] u, input logic [1:0] dn);
        bus.en      = e;
        bus.clr_err = clr;
        bus.d       = dd;
        bus.up      = u;
        bus.down    = dn;
        @(posedge refclk);
        if (!rst_n) mreset();
        else mstep(e, clr, dd, u, dn);
        #1;
        check_all();
    endtask

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic logic [1:0] b0(input bit x);
        return {1'b0, x};
    endfunction

    function automatic logic [1:0] rp();
        return {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, s;
        logic [1:0] dv;
        bit t;
        bit e;
        mreset();
        bus.en = 0; bus.clr_err = 0; bus.d = 0; bus.up = 0; bus.down = 0;

        rst_n = 1'b0;
        repeat (3) step(1, 1, 2'b11, 2'b11, 2'b11);
        chk("rst_locked", bus.locked, 0);
        chk("rst_errs", {bus.err_stuck, bus.err_overlap, bus.err_run}, 0);
        chk("rst_wd", bus.win_done, 0);
        rst_n = 1'b1;

        for (int n = 0; n < 48; n++)
            step(1, 0, rnd2(), b0(n % 4 == 0), b0(n % 4 == 2));
        chk("acq_locked", bus.locked, 2'b01);
        chk("acq_up0", bus.up_cnt[CW-1:0], 4);
        chk("acq_dn0", bus.down_cnt[CW-1:0], 4);
        chk("acq_wd", bus.win_done, 1);

        for (int n = 0; n < 16; n++) step(1, 0, rnd2(), b0(n % 2 == 0), 0);
        chk("hys_hold", bus.locked[0], 1);
        chk("hys_up8", bus.up_cnt[CW-1:0], 8);
        for (int n = 0; n < 32; n++)
            step(1, 0, rnd2(), b0(n % 4 == 0), b0(n % 4 == 2));
        chk("hys_back", bus.locked[0], 1);
        for (int n = 0; n < 16; n++) step(1, 0, rnd2(), b0(n % 2 == 0), 0);
        chk("hys_miss1", bus.locked[0], 1);
        for (int n = 0; n < 16; n++) step(1, 0, rnd2(), b0(n % 2 == 0), 0);
        chk("hys_miss2", bus.locked[0], 0);

        for (int n = 0; n < WL * 8; n++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                 rnd2(), rp(), rp());

        step(1, 1, rnd2(), 0, 0);
        repeat (4) step(1, 0, rnd2(), 2'b01, 0);
        step(1, 0, rnd2(), 0, 0);
        chk("stuck4", bus.err_stuck[0], 0);
        repeat (4) step(1, 0, rnd2(), 2'b01, 0);
        chk("stuck4b", bus.err_stuck[0], 0);
        step(1, 0, rnd2(), 2'b01, 0);
        chk("stuck5", bus.err_stuck[0], 1);
        step(1, 0, rnd2(), 0, 0);
        step(1, 0, rnd2(), 2'b01, 2'b01);
        step(1, 0, rnd2(), 0, 0);
        chk("ovl1", bus.err_overlap[0], 0);
        repeat (2) step(1, 0, rnd2(), 2'b01, 2'b01);
        chk("ovl2", bus.err_overlap[0], 1);

        t = 0;
        step(1, 1, {t, 1'b1}, 0, 0);
        repeat (8) begin t = ~t; step(1, 0, {t, 1'b0}, 0, 0); end
        chk("run8", bus.err_run[0], 0);
        t = ~t; step(1, 0, {t, 1'b1}, 0, 0);
        repeat (9) begin t = ~t; step(1, 0, {t, 1'b0}, 0, 0); end
        chk("run9", bus.err_run[0], 1);
        t = ~t; step(1, 1, {t, 1'b0}, 0, 0);
        chk("run_clr_hold", bus.err_run[0], 1);
        t = ~t; step(1, 0, {t, 1'b1}, 0, 0);
        t = ~t; step(1, 1, {t, 1'b0}, 0, 0);
        chk("run_clr", bus.err_run[0], 0);

        k = 0;
        while (m_pos != 0 && k < WL) begin
            step(1, 0, rnd2(), 0, 0);
            k++;
        end
        s = 0;
        k = 0;
        do begin
            k++;
            e = !(k > 5 && k <= 15);
            step(e, 0, rnd2(), b0(s % 4 == 0), b0(s % 4 == 2));
            if (e) s++;
        end while (!bus.win_done && k < 60);
        chk("gate_delay", k, 26);
        chk("gate_up", bus.up_cnt[CW-1:0], 4);

        rst_n = 1'b0;
        step(1, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int n = 0; n < 55; n++)
            step(1, 0, rnd2(), b0(n % 4 == 0), b0(n % 4 == 2));
        chk("pre_rst_locked", bus.locked[0], 1);
        rst_n = 1'b0;
        step(1, 1, rnd2(), 2'b11, 2'b11);
        chk("mid_rst_locked", bus.locked, 0);
        chk("mid_rst_up", bus.up_cnt, 0);
        chk("mid_rst_dn", bus.down_cnt, 0);
        chk("mid_rst_errs",
            {bus.err_stuck, bus.err_overlap, bus.err_run, bus.win_done}, 0);
        rst_n = 1'b1;
        k = 0;
        do begin
            step(1, 0, rnd2(), b0(k % 4 == 0), b0(k % 4 == 2));
            k++;
        end while (!bus.win_done && k < 40);
        chk("rst_win_len", k, 16);

        for (int n = 0; n < 200; n++) begin
            dv = ($urandom_range(0, 5) == 0) ? ~bus.d : bus.d;
            step($urandom_range(0, 5) != 0, $urandom_range(0, 31) == 0,
                 dv, rp(), rp());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
